// File: rtl/serv_mdu_serial.sv
// serv_mdu_serial
// Serial RISC-V M-extension unit for the SERV core's extension interface.
// A single 32-iteration datapath serves all eight M operations. Multiplies
// use shift-add and divides use restoring division. A one-cycle ready pulse
// returns the 32-bit result.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   i_rst        synchronous, active-high reset
//   i_mdu_valid  request from the core; held high with operands stable until ready
//   i_mdu_rs1    operand A (multiplicand / dividend)
//   i_mdu_rs2    operand B (multiplier / divisor)
//   i_mdu_op     funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   o_mdu_rd     result; valid in the ready cycle and held until the next op
//   o_mdu_ready  single-cycle completion pulse
//
// Optional feature macro: SERV_MDU_EARLY_OUT_EN
//   When defined, a multiply with a zero operand, or a divide or remainder by
//   zero, skips the iteration phase and completes two cycles after the request.
module serv_mdu_serial (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_mdu_valid,
    input  logic [31:0] i_mdu_rs1,
    input  logic [31:0] i_mdu_rs2,
    input  logic [2:0]  i_mdu_op,
    output logic [31:0] o_mdu_rd,
    output logic        o_mdu_ready
);

    typedef enum logic [2:0] {S_IDLE, S_BUSY, S_FIX, S_DONE, S_HOLD} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [63:0] r_acc;     // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] r_opnd;    // mul: multiplicand magnitude; div: divisor magnitude
    logic [2:0]  r_op;
    logic        r_neg;     // result needs negation
    logic        r_bz;      // divisor was zero
    logic [5:0]  r_cnt;
    logic [31:0] r_rd;

    // Decode of the incoming request; used only in IDLE.
    logic        w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg, w_b_zero, w_early;
    logic [31:0] w_a_mag, w_b_mag;

    always_comb begin
        w_is_div   = i_mdu_op[2];
        w_a_signed = w_is_div ? ~i_mdu_op[0] : (i_mdu_op[1:0] == 2'b01 || i_mdu_op[1:0] == 2'b10);
        w_b_signed = w_is_div ? ~i_mdu_op[0] : (i_mdu_op[1:0] == 2'b01);
        w_a_neg    = w_a_signed & i_mdu_rs1[31];
        w_b_neg    = w_b_signed & i_mdu_rs2[31];
        // 0x80000000 negates to itself, which is still the correct unsigned magnitude.
        w_a_mag    = w_a_neg ? (32'd0 - i_mdu_rs1) : i_mdu_rs1;
        w_b_mag    = w_b_neg ? (32'd0 - i_mdu_rs2) : i_mdu_rs2;
        // A remainder takes the dividend's sign. Quotients and products take the XOR of both signs.
        w_neg      = (w_is_div & i_mdu_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
        w_b_zero   = (i_mdu_rs2 == 32'd0);
`ifdef SERV_MDU_EARLY_OUT_EN
        w_early    = w_is_div ? w_b_zero : (w_b_zero || i_mdu_rs1 == 32'd0);
`else
        w_early    = 1'b0;
`endif
    end

    // One iteration of the shared datapath.
    logic [32:0] w_sum, w_rem_sh, w_diff;
    logic [63:0] w_acc_step;

    always_comb begin
        w_sum    = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
        w_rem_sh = {r_acc[63:32], r_acc[31]};
        w_diff   = w_rem_sh - {1'b0, r_opnd};
        if (!r_op[2])
            w_acc_step = {w_sum, r_acc[31:1]};
        else if (!w_diff[32])
            w_acc_step = {w_diff[31:0], r_acc[30:0], 1'b1};
        else
            w_acc_step = {w_rem_sh[31:0], r_acc[30:0], 1'b0};
    end

    // Sign fix and result selection.
    logic [63:0] w_prod;
    logic [31:0] w_quo, w_rem, w_fix_rd;

    always_comb begin
        w_prod = r_neg ? (64'd0 - r_acc) : r_acc;
        w_quo  = r_neg ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
        // A zero divisor leaves |rs1| in the remainder, so the sign fix restores rs1 exactly.
        w_rem  = r_neg ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
        case (r_op)
            3'b000:         w_fix_rd = w_prod[31:0];
            3'b001, 3'b010,
            3'b011:         w_fix_rd = w_prod[63:32];
            3'b100, 3'b101: w_fix_rd = r_bz ? 32'hFFFF_FFFF : w_quo;
            default:        w_fix_rd = w_rem;
        endcase
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // FSM: next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_mdu_valid) w_state_next = w_early ? S_FIX : S_BUSY;
            S_BUSY:  if (r_cnt == 6'd31) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_HOLD;
            S_HOLD:  if (!i_mdu_valid) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_acc  <= 64'd0;
            r_opnd <= 32'd0;
            r_op   <= 3'd0;
            r_neg  <= 1'b0;
            r_bz   <= 1'b0;
            r_cnt  <= 6'd0;
            r_rd   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: if (i_mdu_valid) begin
                    r_op   <= i_mdu_op;
                    r_neg  <= w_neg;
                    r_bz   <= w_is_div & w_b_zero;
                    r_cnt  <= 6'd0;
                    r_opnd <= w_is_div ? w_b_mag : w_a_mag;
                    if (w_early)
                        // Preset: zero product, or all-ones quotient with |rs1| as the remainder.
                        r_acc <= w_is_div ? {w_a_mag, 32'hFFFF_FFFF} : 64'd0;
                    else
                        r_acc <= {32'd0, (w_is_div ? w_a_mag : w_b_mag)};
                end
                S_BUSY: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt + 6'd1;
                end
                S_FIX:  r_rd <= w_fix_rd;
                default: ;
            endcase
        end
    end

    assign o_mdu_rd    = r_rd;
    assign o_mdu_ready = (r_state == S_DONE);

endmodule

// File: tb/tb_serv_mdu_serial.sv
// Directed testbench for serv_mdu_serial.
// The bench hand-computes each expected result and ready latency. Latency is
// counted in rising edges, from the edge that first samples valid to the edge
// that samples ready.
module tb_serv_mdu_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        mdu_valid;
    logic [31:0] mdu_rs1, mdu_rs2;
    logic [2:0]  mdu_op;
    logic [31:0] o_mdu_rd;
    logic        o_mdu_ready;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SERV_MDU_EARLY_OUT_EN
    localparam int LAT_Z = 2;
`else
    localparam int LAT_Z = 34;
`endif

    serv_mdu_serial dut (
        .clk         (clk),
        .i_rst       (rst),
        .i_mdu_valid (mdu_valid),
        .i_mdu_rs1   (mdu_rs1),
        .i_mdu_rs2   (mdu_rs2),
        .i_mdu_op    (mdu_op),
        .o_mdu_rd    (o_mdu_rd),
        .o_mdu_ready (o_mdu_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // The caller must already be at a falling edge. The task returns at a falling edge after one low-valid cycle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int hold);
        int lat;
        lat = 0;
        mdu_op = op; mdu_rs1 = a; mdu_rs2 = b; mdu_valid = 1'b1;
        for (int i = 1; i <= 100 && lat == 0; i++) begin
            @(negedge clk);
            if (o_mdu_ready) lat = i;
            // Operands change mid-operation and must be ignored.
            if (i == 3) begin mdu_rs1 = ~a; mdu_rs2 = ~b; end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rd"}, o_mdu_rd, exp);
        for (int i = 0; i <= hold; i++) begin
            @(negedge clk);
            check({tag, "_pulse"}, {31'd0, o_mdu_ready}, 32'd0);
        end
        mdu_valid = 1'b0;
        @(negedge clk);
        check({tag, "_held"}, o_mdu_rd, exp);
        $display("op %s: rs1=0x%08h rs2=0x%08h rd=0x%08h latency=%0d", tag, a, b, o_mdu_rd, lat);
    endtask

    initial begin
        int n_ready;
        rst = 1'b1; mdu_valid = 1'b0; mdu_op = 3'd0; mdu_rs1 = 32'd0; mdu_rs2 = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_rd", o_mdu_rd, 32'd0);
        check("reset_ready", {31'd0, o_mdu_ready}, 32'd0);

        run_op("mul",    3'b000, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 34, 3);
        run_op("mulh",   3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34, 0);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
        run_op("div",    3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, 0);
        run_op("rem",    3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, 0);
        run_op("divu",   3'b101, 32'd100,        32'd7,         32'd14,        34, 0);
        run_op("remu",   3'b111, 32'd100,        32'd7,         32'd2,         34, 0);
        run_op("div_ov", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34, 0);
        run_op("rem_ov", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         34, 1);
        run_op("div_z",  3'b100, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, LAT_Z, 0);
        run_op("rem_z",  3'b110, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, LAT_Z, 0);
        run_op("mul_z",  3'b000, 32'd0,          32'd5,         32'd0,         LAT_Z, 0);

        // Reset in the middle of an operation.
        mdu_op = 3'b101; mdu_rs1 = 32'd100; mdu_rs2 = 32'd7; mdu_valid = 1'b1;
        repeat (16) @(negedge clk);
        rst = 1'b1; mdu_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_rd", o_mdu_rd, 32'd0);
        n_ready = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_mdu_ready) n_ready++;
        end
        check("rst_mid_noready", 32'(n_ready), 32'd0);
        $display("op rst_mid: rd=0x%08h ready_pulses=%0d", o_mdu_rd, n_ready);

        run_op("mul_after_rst", 3'b000, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 34, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
